// File: rtl/fault_campaign_seq.sv
// Fault-campaign sequencer: golden pass over all input vectors, then every
// site x stuck-at value, comparing each faulty response with the golden one
// and building a per-fault detection bitmap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, outputs parked, bitmap held
// S_GOLD   | sel=0, sweep vectors, store golden responses
// S_FAULT  | sweep vectors per fault, compare against golden responses
// S_FINISH | outputs parked, done pulses for one cycle
module fault_campaign_seq #(
    parameter int N_SITES    = 16,
    parameter int N_IN       = 4,
    parameter int SETTLE     = 2,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic [4:0]           o_sel,
    output logic                 o_control,
    output logic [N_IN-1:0]      o_vec,
    input  logic                 i_dut_y,
    input  logic                 i_dut_z,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*N_SITES-1:0] o_detected,
    output logic [5:0]           o_det_count
);

    localparam int NV = 1 << N_IN;
    localparam int DW = 2 * N_SITES;
    localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int IW = $clog2(DW);
    localparam logic [HW-1:0] HOLD_INIT = HW'(SETTLE - 1);
    localparam logic [4:0]    SEL_LAST  = 5'(N_SITES);

    typedef enum logic [1:0] {S_IDLE, S_GOLD, S_FAULT, S_FINISH} state_t;

    state_t          r_state, w_state_nxt;
    logic [4:0]      r_sel, w_sel_nxt;
    logic            r_ctrl, w_ctrl_nxt;
    logic [N_IN-1:0] r_vec, w_vec_nxt;
    logic [HW-1:0]   r_hold, w_hold_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic [DW-1:0]   r_det, w_det_nxt;
    logic [5:0]      r_cnt, w_cnt_nxt;
    logic            w_gold_we;
    logic [1:0]      r_gold [NV];

    logic [1:0]      w_resp;
    logic            w_last;
    logic            w_vec_last;
    logic            w_fault_last;
    logic            w_mismatch;
    logic            w_fault_end;
    logic [IW-1:0]   w_det_idx;
    logic [DW-1:0]   w_det_bit;

    // The response is sampled on the last held cycle of each vector; the
    // bitmap index is (sel-1)*2 + control.
    assign w_resp       = {i_dut_y, i_dut_z};
    assign w_last       = (r_hold == '0);
    assign w_vec_last   = (r_vec == '1);
    assign w_fault_last = (r_sel == SEL_LAST) && r_ctrl;
    assign w_mismatch   = (w_resp != r_gold[r_vec]);
    assign w_fault_end  = w_last && (w_vec_last || (EARLY_EXIT && w_mismatch));
    assign w_det_idx    = IW'({r_sel - 5'd1, r_ctrl});
    assign w_det_bit    = DW'(1) << w_det_idx;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_state_nxt = S_GOLD;
            S_GOLD:   if (w_last && w_vec_last) w_state_nxt = S_FAULT;
            S_FAULT:  if (w_fault_end && w_fault_last) w_state_nxt = S_FINISH;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and sweep counters.
    always_comb begin
        w_sel_nxt  = r_sel;
        w_ctrl_nxt = r_ctrl;
        w_vec_nxt  = r_vec;
        w_hold_nxt = r_hold;
        w_busy_nxt = r_busy;
        w_done_nxt = 1'b0;
        w_det_nxt  = r_det;
        w_cnt_nxt  = r_cnt;
        w_gold_we  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_sel_nxt  = 5'd0;
                    w_ctrl_nxt = 1'b0;
                    w_vec_nxt  = '0;
                    w_hold_nxt = HOLD_INIT;
                    w_busy_nxt = 1'b1;
                    w_det_nxt  = '0;
                    w_cnt_nxt  = 6'd0;
                end
            end
            S_GOLD: begin
                if (w_last) begin
                    w_gold_we  = 1'b1;
                    w_hold_nxt = HOLD_INIT;
                    w_vec_nxt  = r_vec + 1'b1;
                    if (w_vec_last) w_sel_nxt = 5'd1;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            S_FAULT: begin
                if (w_last) begin
                    w_hold_nxt = HOLD_INIT;
                    w_vec_nxt  = r_vec + 1'b1;
                    if (w_mismatch) begin
                        w_det_nxt = r_det | w_det_bit;
                        if (!r_det[w_det_idx]) w_cnt_nxt = r_cnt + 6'd1;
                    end
                    if (w_fault_end) begin
                        w_vec_nxt = '0;
                        if (w_fault_last) begin
                            w_sel_nxt  = 5'd0;
                            w_ctrl_nxt = 1'b0;
                            w_busy_nxt = 1'b0;
                            w_done_nxt = 1'b1;
                        end else if (r_ctrl) begin
                            w_sel_nxt  = r_sel + 5'd1;
                            w_ctrl_nxt = 1'b0;
                        end else begin
                            w_ctrl_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            S_FINISH: begin
                w_sel_nxt  = 5'd0;
                w_ctrl_nxt = 1'b0;
                w_vec_nxt  = '0;
                w_busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered outputs and sweep counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel  <= 5'd0;
            r_ctrl <= 1'b0;
            r_vec  <= '0;
            r_hold <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_det  <= '0;
            r_cnt  <= 6'd0;
        end else begin
            r_sel  <= w_sel_nxt;
            r_ctrl <= w_ctrl_nxt;
            r_vec  <= w_vec_nxt;
            r_hold <= w_hold_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_det  <= w_det_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // Golden response store; contents are only read after a full golden pass.
    always_ff @(posedge i_clk) begin
        if (w_gold_we) r_gold[r_vec] <= w_resp;
    end

    assign o_sel       = r_sel;
    assign o_control   = r_ctrl;
    assign o_vec       = r_vec;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_detected  = r_det;
    assign o_det_count = r_cnt;

endmodule

// File: tb/tb_fault_campaign_seq.sv
// Bench for fault_campaign_seq: a behavioural wrapper model (golden table plus
// per-fault flip masks) and a reference trace of the expected output sequence.
module tb_fault_campaign_seq;

    localparam int SETTLE = 2;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [4:0]  o_sel;
    logic        o_control;
    logic [3:0]  o_vec;
    logic        dut_y;
    logic        dut_z;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_detected;
    logic [5:0]  o_det_count;

    fault_campaign_seq #(
        .N_SITES(16), .N_IN(4), .SETTLE(SETTLE), .EARLY_EXIT(1'b1)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .o_sel(o_sel), .o_control(o_control), .o_vec(o_vec),
        .i_dut_y(dut_y), .i_dut_z(dut_z),
        .o_busy(o_busy), .o_done(o_done),
        .o_detected(o_detected), .o_det_count(o_det_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapper model: golden table per vector; fault k flips outputs eff[k]
    // on every vector whose bit is set in mask[k].
    logic [1:0]  base [16];
    logic [15:0] mask [32];
    logic [1:0]  eff  [32];
    logic [1:0]  m_resp;
    int          m_idx;

    always_comb begin
        m_idx  = 0;
        m_resp = base[o_vec];
        if (o_sel != 5'd0 && o_sel <= 5'd16) begin
            m_idx = (int'(o_sel) - 1) * 2 + int'(o_control);
            if (mask[m_idx][o_vec]) m_resp = m_resp ^ eff[m_idx];
        end
        {dut_y, dut_z} = m_resp;
    end

    typedef struct packed {
        logic [4:0] sel;
        logic       ctrl;
        logic [3:0] vec;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t        exp_q [$];
    bit          tracking;
    int          n_checks;
    int          n_fail;
    logic [31:0] exp_det;
    int          exp_cnt;
    int          exp_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison of the output sequence against the reference trace.
    always @(negedge clk) begin
        if (tracking) begin
            if (exp_q.size() == 0) begin
                chk("trace_overrun", 64'(1), 64'(0));
                tracking = 1'b0;
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sel",     64'(o_sel),     64'(e.sel));
                chk("control", 64'(o_control), 64'(e.ctrl));
                chk("vec",     64'(o_vec),     64'(e.vec));
                chk("busy",    64'(o_busy),    64'(e.busy));
                chk("done",    64'(o_done),    64'(e.done));
            end
        end
    end

    task automatic push_e(input int s, input int c, input int v, input bit b, input bit d);
        exp_t e;
        e.sel  = 5'(s);
        e.ctrl = c[0];
        e.vec  = 4'(v);
        e.busy = b;
        e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic setup(input int mode);
        for (int i = 0; i < 16; i++) base[i] = 2'($urandom_range(0, 3));
        for (int k = 0; k < 32; k++) begin
            eff[k] = 2'b10;
            case (mode)
                0: mask[k] = 16'h0000;
                1: mask[k] = (k == 1) ? 16'hFFFF : 16'h0000;
                2: mask[k] = 16'h8000;
                3: begin
                    mask[k] = 16'($urandom) << $urandom_range(0, 15);
                    eff[k]  = 2'($urandom_range(1, 3));
                end
                default: begin
                    mask[k] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
                    eff[k]  = 2'($urandom_range(1, 3));
                end
            endcase
        end
    endtask

    // Reference: golden sweep, then each fault sweeps vectors until its first
    // flipping vector (inclusive) or all 16; then one done cycle and idle.
    task automatic build_ref();
        exp_q.delete();
        exp_det = 32'h0;
        exp_cnt = 0;
        for (int v = 0; v < 16; v++)
            for (int h = 0; h < SETTLE; h++) push_e(0, 0, v, 1'b1, 1'b0);
        for (int s = 1; s <= 16; s++) begin
            for (int c = 0; c < 2; c++) begin
                int k;
                int nv;
                k  = (s - 1) * 2 + c;
                nv = 16;
                if (mask[k] != 16'h0 && eff[k] != 2'b00) begin
                    for (int v = 15; v >= 0; v--) if (mask[k][v]) nv = v + 1;
                    exp_det[k] = 1'b1;
                    exp_cnt++;
                end
                for (int v = 0; v < nv; v++)
                    for (int h = 0; h < SETTLE; h++) push_e(s, c, v, 1'b1, 1'b0);
            end
        end
        push_e(0, 0, 0, 1'b0, 1'b1);
        exp_done = exp_q.size();
        push_e(0, 0, 0, 1'b0, 1'b0);
        push_e(0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic run(input int mode, input int restart_at, input int rst_at,
                       input bit start_on_done, input int lit_done,
                       input bit lit_chk, input logic [31:0] lit_det, input int lit_cnt);
        int  cnt;
        bit  seen;
        setup(mode);
        build_ref();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        tracking = 1'b1;
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 3000) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                chk("det_cleared", 64'(o_detected), 64'(0));
                chk("cnt_cleared", 64'(o_det_count), 64'(0));
            end
            if (cnt == restart_at) i_start = 1'b1;
            if (cnt == restart_at + 1) i_start = 1'b0;
            if (cnt == rst_at) begin
                i_rst = 1'b1;
                tracking = 1'b0;
                exp_q.delete();
            end
            if (rst_at > 0 && cnt == rst_at + 1) begin
                chk("rst_sel",  64'(o_sel),       64'(0));
                chk("rst_busy", 64'(o_busy),      64'(0));
                chk("rst_det",  64'(o_detected),  64'(0));
                chk("rst_cnt",  64'(o_det_count), 64'(0));
                chk("rst_vec",  64'(o_vec),       64'(0));
                i_rst = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("rst_no_done", 64'(o_done), 64'(0));
                    chk("rst_idle",    64'(o_busy), 64'(0));
                end
                return;
            end
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("done_timeout", 64'(0), 64'(1));
            tracking = 1'b0;
            exp_q.delete();
            return;
        end
        chk("done_cycle", 64'(cnt), 64'(exp_done));
        chk("detected",   64'(o_detected), 64'(exp_det));
        chk("det_count",  64'(o_det_count), 64'(exp_cnt));
        if (lit_done > 0) chk("lit_done_cycle", 64'(cnt), 64'(lit_done));
        if (lit_chk) begin
            chk("lit_detected", 64'(o_detected), 64'(lit_det));
            chk("lit_det_count", 64'(o_det_count), 64'(lit_cnt));
        end
        if (start_on_done) i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        #1;
        chk("trace_len", 64'(exp_q.size()), 64'(0));
        tracking = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tracking = 1'b0;
        i_rst    = 1'b1;
        i_start  = 1'b0;
        setup(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_sel",     64'(o_sel),       64'(0));
        chk("reset_control", 64'(o_control),   64'(0));
        chk("reset_vec",     64'(o_vec),       64'(0));
        chk("reset_busy",    64'(o_busy),      64'(0));
        chk("reset_done",    64'(o_done),      64'(0));
        chk("reset_det",     64'(o_detected),  64'(0));
        chk("reset_cnt",     64'(o_det_count), 64'(0));
        i_rst = 1'b0;

        run(0, 0, 0, 1'b0, 1057, 1'b1, 32'h0000_0000, 0);
        run(1, 0, 0, 1'b0, 1027, 1'b1, 32'h0000_0002, 1);
        run(2, 0, 0, 1'b1, 1057, 1'b1, 32'hFFFF_FFFF, 32);
        run(4, 500, 0, 1'b0, 1057, 1'b0, 32'h0, 0);
        run(3, 0, 0, 1'b0, 0, 1'b0, 32'h0, 0);
        run(3, 0, 0, 1'b1, 0, 1'b0, 32'h0, 0);
        run(4, 0, 700, 1'b0, 0, 1'b0, 32'h0, 0);
        run(3, 0, 0, 1'b0, 0, 1'b0, 32'h0, 0);
        run(4, 0, 0, 1'b0, 1057, 1'b0, 32'h0, 0);
        run(3, 0, 0, 1'b0, 0, 1'b0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
